// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM bank: register map offsets
// (relative to the first address after the duty registers) and period length.
package pwm_pkg;

    // Control/config registers sit directly above the per-channel duty registers.
    localparam int REG_CTRL_OFS = 0;
    localparam int REG_INV_OFS  = 1;
    localparam int REG_PRE_OFS  = 2;

    // Bit position of the global enable inside the ctrl register.
    localparam int CTRL_EN_BIT  = 0;

    // Ticks per PWM period: the counter spans 0..2^width-2, so a duty of
    // 2^width-1 is high on every tick (exact 100%).
    function automatic int period_len(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared timebase for all channels: prescaler producing a tick, and the
// period counter advanced by that tick. Both are held at zero while disabled.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic [WIDTH-1:0]      o_cnt,
    output logic                  o_wrap
);

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(period_len(WIDTH) - 1);

    logic [PRESCALE_W-1:0] r_pre_cnt;
    logic [WIDTH-1:0]      r_cnt;
    logic                  w_tick;

    // Equality compare (not >=) so a divisor lowered below the running count
    // lets the prescaler run out to all-ones and wrap instead of ticking early.
    assign w_tick = i_enable && (r_pre_cnt == i_prescale);
    assign o_wrap = w_tick && (r_cnt == CNT_LAST);
    assign o_cnt  = r_cnt;

    // Prescaler: count 0..prescale, restart on tick, free-wrap through all-ones.
    // NOTE: non-blocking assignments in clocked blocks so every register sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre_cnt <= '0;
        end else if (!i_enable || w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
        end
    end

    // Period counter: advance on tick, wrap after the last tick of the period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_enable || o_wrap) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_bank.sv
// N-channel PWM bank with register write/read port, double-buffered duty
// registers loaded at period boundaries, global enable and per-channel invert.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int CHANNELS   = 8,
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 16,
    parameter int ADDR_W     = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [15:0]         wr_data,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [15:0]         rd_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(CHANNELS + REG_CTRL_OFS);
    localparam logic [ADDR_W-1:0] A_INV  = ADDR_W'(CHANNELS + REG_INV_OFS);
    localparam logic [ADDR_W-1:0] A_PRE  = ADDR_W'(CHANNELS + REG_PRE_OFS);

    logic [WIDTH-1:0]      r_duty     [CHANNELS];
    logic [WIDTH-1:0]      r_shadow   [CHANNELS];
    logic [WIDTH-1:0]      w_duty_nxt [CHANNELS];
    logic                  r_enable;
    logic [CHANNELS-1:0]   r_inv;
    logic [PRESCALE_W-1:0] r_pre;
    logic [15:0]           r_rd_data;
    logic [15:0]           w_rd_mux;
    logic [CHANNELS-1:0]   r_pwm;
    logic [CHANNELS-1:0]   w_raw;
    logic                  r_period_start;
    logic [WIDTH-1:0]      w_cnt;
    logic                  w_wrap;
    logic                  w_wr_ctrl;
    logic                  w_wr_inv;
    logic                  w_wr_pre;

    assign w_wr_ctrl = wr_en && (wr_addr == A_CTRL);
    assign w_wr_inv  = wr_en && (wr_addr == A_INV);
    assign w_wr_pre  = wr_en && (wr_addr == A_PRE);

    pwm_timebase #(
        .WIDTH      (WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) u_timebase (
        .clk        (clk),
        .rst        (rst),
        .i_enable   (r_enable),
        .i_prescale (r_pre),
        .o_cnt      (w_cnt),
        .o_wrap     (w_wrap)
    );

    // Per-channel duty write-through value and compare against the shared counter.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign w_duty_nxt[g] = (wr_en && (wr_addr == ADDR_W'(g))) ? wr_data[WIDTH-1:0] : r_duty[g];
        assign w_raw[g]      = r_enable && (w_cnt < r_shadow[g]);
    end

    // Register file: duty, ctrl, invert mask and prescale divisor.
    // NOTE: the duty array is a handful of flops, not a RAM, so it takes the
    // async reset like any other state; a true memory would be left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty[i] <= '0;
            end
            r_enable <= 1'b0;
            r_inv    <= '0;
            r_pre    <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty[i] <= w_duty_nxt[i];
            end
            if (w_wr_ctrl) r_enable <= wr_data[CTRL_EN_BIT];
            if (w_wr_inv)  r_inv    <= wr_data[CHANNELS-1:0];
            if (w_wr_pre)  r_pre    <= wr_data[PRESCALE_W-1:0];
        end
    end

    // Shadow duty: follows duty while idle, otherwise reloads only at the wrap,
    // taking a same-cycle write so it is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (!r_enable || w_wrap) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_shadow[i] <= w_duty_nxt[i];
            end
        end
    end

    // Registered outputs; raw is forced low while disabled so outputs show the invert mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_pwm          <= w_raw ^ r_inv;
            r_period_start <= w_wrap;
        end
    end

    // Readback mux: unmapped addresses and unused upper bits read zero.
    // NOTE: default assigned first so every path drives w_rd_mux and no latch is inferred.
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_addr == ADDR_W'(i)) w_rd_mux = 16'(r_duty[i]);
        end
        if (rd_addr == A_CTRL) w_rd_mux = 16'(r_enable);
        if (rd_addr == A_INV)  w_rd_mux = 16'(r_inv);
        if (rd_addr == A_PRE)  w_rd_mux = 16'(r_pre);
    end

    // Readback register: one clock of latency, old value on a same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign rd_data      = r_rd_data;
    assign pwm_out      = r_pwm;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank at default parameters: readback, duty sweep,
// shadow update timing, prescaler (including run-out), invert/enable, reset.
module tb_pwm_bank;

    localparam int CH     = 8;
    localparam int WD     = 8;
    localparam int PW     = 16;
    localparam int AW     = 5;
    localparam int A_CTRL = CH;
    localparam int A_INV  = CH + 1;
    localparam int A_PRE  = CH + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data;
    logic [CH-1:0] pwm_out;
    logic          period_start;

    int n_checks = 0;
    int n_errors = 0;
    int hi [CH];
    int ps_seen;

    always #5 clk = ~clk;

    pwm_bank #(
        .CHANNELS   (CH),
        .WIDTH      (WD),
        .PRESCALE_W (PW),
        .ADDR_W     (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic write_reg(input int addr, input int data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = 16'(data);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic read_reg(input int addr, output int data);
        @(negedge clk);
        rd_addr = AW'(addr);
        @(negedge clk);
        data = int'(rd_data);
    endtask

    // Returns the number of negedges until period_start is seen, 0 on timeout.
    task automatic wait_ps(input int limit, output int waited);
        int i;
        waited = 0;
        i = 0;
        while (waited == 0 && i < limit) begin
            @(negedge clk);
            i++;
            if (period_start) waited = i;
        end
    endtask

    task automatic count_window(input int n);
        for (int c = 0; c < CH; c++) hi[c] = 0;
        ps_seen = 0;
        repeat (n) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) hi[c] += int'(pwm_out[c]);
            ps_seen += int'(period_start);
        end
    endtask

    // One 255-clk period starting right after a period_start sample; optional
    // duty[0] write driven on sample wk (0 = no write).
    task automatic period_with_write(input int wk, input int wdat, output int high);
        high = 0;
        for (int k = 1; k <= 255; k++) begin
            @(negedge clk);
            high += int'(pwm_out[0]);
            if (k == wk) begin
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_data = 16'(wdat);
            end else begin
                wr_en = 1'b0;
            end
        end
        wr_en = 1'b0;
    endtask

    initial begin
        int d;
        int w;
        int h;

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_rd", int'(rd_data), 0);
        check("rst_ps", int'(period_start), 0);
        rst = 1'b0;

        // Readback of every register plus unmapped addresses.
        for (int i = 0; i < CH; i++) write_reg(i, 'hFF00 | (i * 29 + 5));
        write_reg(A_CTRL, 'hFFFE);
        write_reg(A_INV, 'hFFA5);
        write_reg(A_PRE, 'h1234);
        write_reg(11, 'hBEEF);
        write_reg(31, 'hFFFF);
        for (int i = 0; i < CH; i++) begin
            read_reg(i, d);
            check($sformatf("rd_duty%0d", i), d, i * 29 + 5);
        end
        read_reg(A_CTRL, d); check("rd_ctrl", d, 0);
        read_reg(A_INV, d);  check("rd_inv", d, 'hA5);
        read_reg(A_PRE, d);  check("rd_pre", d, 'h1234);
        read_reg(11, d);     check("rd_unused11", d, 0);
        read_reg(31, d);     check("rd_unused31", d, 0);
        check("dis_pwm_inv", int'(pwm_out), 'hA5);

        // Same-cycle write to the address being read returns the old value.
        @(negedge clk);
        rd_addr = '0;
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = 16'h0055;
        @(negedge clk);
        wr_en = 1'b0;
        check("rd_same_cycle_old", int'(rd_data), 5);
        @(negedge clk);
        check("rd_after_write", int'(rd_data), 'h55);

        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;

        // Duty sweep at prescale 0.
        write_reg(0, 0);
        write_reg(1, 1);
        write_reg(2, 128);
        write_reg(3, 255);
        write_reg(A_CTRL, 1);
        @(negedge clk); check("en_first_cnt0", int'(pwm_out[3:0]), 'b1110);
        @(negedge clk); check("en_first_cnt1", int'(pwm_out[3:0]), 'b1100);
        count_window(255);
        check("sweep_d0", hi[0], 0);
        check("sweep_d1", hi[1], 1);
        check("sweep_d128", hi[2], 128);
        check("sweep_d255", hi[3], 255);
        check("sweep_ps_count", ps_seen, 1);
        wait_ps(300, w); check("sweep_ps_seen", int'(w > 0), 1);
        wait_ps(300, w); check("sweep_ps_spacing", w, 255);
        read_reg(A_CTRL, d); check("rd_ctrl_en", d, 1);

        // Shadow update: mid-period write deferred, wrap-cycle write taken at once.
        write_reg(0, 200);
        wait_ps(300, w); check("glitch_ps_seen", int'(w > 0), 1);
        period_with_write(50, 10, h);  check("glitch_cur_period", h, 200);
        period_with_write(254, 77, h); check("glitch_next_period", h, 10);
        period_with_write(0, 0, h);    check("wrap_write_through", h, 77);

        // Prescaler 3: tick every 4 clks.
        write_reg(0, 64);
        write_reg(A_PRE, 3);
        wait_ps(2000, w); check("pre_ps_seen", int'(w > 0), 1);
        count_window(1020);
        check("pre_high_d64", hi[0], 256);
        check("pre_high_d128", hi[2], 512);
        check("pre_ps_count", ps_seen, 1);
        check("pre_ps_at_end", int'(period_start), 1);

        // Lower divisor below the running count: run-out to all-ones then wrap.
        write_reg(A_PRE, 1);
        wait_ps(70000, w); check("pre_runout", w, 66044);
        wait_ps(600, w);   check("pre1_spacing", w, 510);
        write_reg(A_PRE, 0);

        // Invert and enable.
        write_reg(A_CTRL, 0);
        write_reg(0, 0);
        write_reg(1, 128);
        write_reg(A_INV, 1);
        @(negedge clk); check("inv_disabled", int'(pwm_out[1:0]), 1);
        write_reg(A_CTRL, 1);
        @(negedge clk); check("inv_enabled", int'(pwm_out[1:0]), 3);
        count_window(255);
        check("inv_d0_full", hi[0], 255);
        check("inv_d128", hi[1], 128);
        wait_ps(300, w); check("dis_ps_seen", int'(w > 0), 1);
        repeat (50) @(negedge clk);
        write_reg(A_CTRL, 0);
        check("dis_before", int'(pwm_out[1:0]), 3);
        @(negedge clk); check("dis_after", int'(pwm_out[1:0]), 1);
        count_window(300);
        check("dis_ps_silent", ps_seen, 0);
        check("dis_ch0_inv", hi[0], 300);
        check("dis_ch1_low", hi[1], 0);
        write_reg(A_CTRL, 1);
        wait_ps(400, w); check("reen_from_cnt0", w, 255);

        // Asynchronous reset mid-period.
        @(negedge clk); rd_addr = AW'(A_INV);
        @(negedge clk); check("pre_rst_rd", int'(rd_data), 1);
        #3 rst = 1'b1;
        #1;
        check("midrst_pwm", int'(pwm_out), 0);
        check("midrst_rd", int'(rd_data), 0);
        check("midrst_ps", int'(period_start), 0);
        @(negedge clk); rst = 1'b0;
        read_reg(A_PRE, d);  check("post_rst_pre", d, 0);
        read_reg(A_INV, d);  check("post_rst_inv", d, 0);
        read_reg(A_CTRL, d); check("post_rst_ctrl", d, 0);
        count_window(20);
        check("post_rst_pwm_low", hi[0] + hi[1] + hi[2] + hi[3], 0);
        check("post_rst_ps", ps_seen, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_bank.md
Name: pwm_bank

Overview:
- Parametrised N-channel PWM generator with a register write/read port; successor to the fixed 8-channel, 8-bit LED PWM.
- Adds per-channel duty registers, shadow (double-buffered) duty updates at period boundaries for glitch-free changes, and a programmable prescaler.
- Adds a global enable, a per-channel invert, and exact 0% and 100% duty.
- Sits between the I2C slave register interface and the PMOD LED pins.

Parameters:
- CHANNELS, 8, number of PWM outputs (1..16).
- WIDTH, 8, duty resolution in bits; period = 2^WIDTH-1 ticks.
- PRESCALE_W, 16, width of the prescaler divisor register.
- ADDR_W, 5, register address width; must satisfy 2^ADDR_W >= CHANNELS+3.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- wr_en  in  1  register write strobe, one clk per write
- wr_addr  in  ADDR_W  write address
- wr_data  in  16  write data; low WIDTH bits used for duty
- rd_addr  in  ADDR_W  read address
- rd_data  out  16  registered readback of rd_addr
- pwm_out  out  CHANNELS  PWM outputs, bit i = channel i
- period_start  out  1  one-clk pulse at each period wrap

Behaviour:
- Register map:
  - 0..CHANNELS-1: duty[i], WIDTH bits.
  - CHANNELS: ctrl; bit0 = enable.
  - CHANNELS+1: invert mask, CHANNELS bits.
  - CHANNELS+2: prescale divisor, PRESCALE_W bits.
  - Other addresses: writes ignored, reads return 0.
- Reset (async, all outputs/state):
  - duty = 0, ctrl = 0, invert = 0, prescale = 0.
  - shadow = 0, pre_cnt = 0, cnt = 0.
  - pwm_out = 0, period_start = 0, rd_data = 0.
- Readback:
  - rd_data <= register[rd_addr] every clk; 1-clk latency.
  - Unused upper bits read 0.
  - A same-cycle write to rd_addr returns the old value.
- Prescaler:
  - pre_cnt counts 0..prescale; tick asserted when pre_cnt == prescale, then pre_cnt wraps to 0.
  - prescale = 0 gives a tick every clk.
  - A prescale write takes effect on the next compare; if the new value is below pre_cnt, pre_cnt runs to all-ones and wraps to 0 (no lockup).
- Period counter:
  - cnt advances on tick through 0..2^WIDTH-2, then wraps to 0.
  - Wrap event = tick && cnt == 2^WIDTH-2.
- Shadow update:
  - On wrap event, shadow[i] <= duty[i] for all channels simultaneously.
  - A duty write in the same cycle as a wrap event is captured: write-through to the shadow.
  - Duty writes otherwise take effect only at the next period start; never mid-period.
- Output:
  - raw[i] = enable && (cnt < shadow[i]).
  - pwm_out[i] <= raw[i] XOR invert[i] when enable, else invert[i]; registered, 1-clk latency.
  - duty 0 → raw always 0; duty 2^WIDTH-1 → raw always 1 (exact 100%).
- period_start <= wrap event; one clk wide.
- Enable:
  - While enable = 0: pre_cnt and cnt held at 0, shadow tracks duty every clk, period_start = 0.
  - On enable 0→1: first period starts at cnt = 0 with the current duty; first output valid next clk.
  - enable 1→0: counters clear on the next clk; outputs go to invert[i] on the next clk.
- Reset asserted mid-period: immediate clear of all state; no partial pulse after release.

Decomposition:
- Shared package pwm_pkg:
  - Register address constants: REG_CTRL_OFS, REG_INV_OFS, REG_PRE_OFS (offsets from CHANNELS).
  - CTRL_EN_BIT.
  - Function for period length, 2^WIDTH-1.
- One sub-module pwm_timebase: prescaler + period counter, outputs cnt, tick, wrap.
- Channel compare stays in a generate loop in pwm_bank.

Test Plan:
- Reset/defaults: assert rst mid-run → pwm_out = 0, rd_data = 0; read addr CHANNELS+2 → 0.
- Duty sweep (WIDTH=8, prescale=0): duty[0]=0, duty[1]=1, duty[2]=128, duty[3]=255, enable=1.
  - Over one 255-clk period, high counts are 0, 1, 128, 255.
  - period_start pulses every 255 clks.
- Glitch-free update: duty[0]=200; write duty[0]=10 at cnt=50.
  - Current period still high for 200 clks.
  - Next period high for 10 clks.
  - Write on the exact wrap cycle → new value used immediately.
- Prescaler: prescale=3 → tick every 4 clks, period 1020 clks; duty=64 → high 256 clks.
  - Write prescale=1 while pre_cnt=2 → pre_cnt wraps, no lockup.
- Invert/enable: invert=0x01, duty[0]=0, enable=0 → pwm_out[0]=1.
  - enable=1 → pwm_out[0] stays 1.
  - Toggle enable off mid-period → cnt back to 0 next clk, period_start silent.
- Readback: write every register including an unused address, then read each.
  - Written values returned with 1-clk latency; unused address reads 0; upper bits 0.
